hyper_wr_packer: RTL and testbench

- Upstream feeder for hyper_xface in the Boson frame-grabber path.
- Accepts the 16-bit pixel stream from the Boson capture logic, packs pixel pairs into dwords and buffers them in a small FIFO.
- Issues single-dword memory write requests to hyper_xface at a linearly incrementing HyperRAM address, restarting at a base address on each start-of-frame.
- The video stream cannot be stalled: on FIFO overflow, data is dropped and flagged.

---
 rtl/hyper_wr_packer.sv | 184 ++++++++++++++++++
 tb/tb_hyper_wr_packer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_wr_packer.sv
// Packs 16-bit Boson pixels into dwords, buffers them and issues single-dword writes to hyper_xface.
// Optional statistics outputs (frame_cnt, drop_cnt) are built when HYPER_WR_PACKER_STATS_EN is defined.
module hyper_wr_packer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] ADDR_LIMIT = 32'h0040_0000
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            pix_valid,
    input  logic [15:0]                     pix_data,
    input  logic                            pix_sof,
    output logic                            wr_req,
    output logic [31:0]                     addr,
    output logic [31:0]                     wr_d,
    output logic [3:0]                      wr_byte_en,
    output logic                            mem_or_reg,
    input  logic                            busy,
    input  logic                            burst_wr_rdy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
`ifdef HYPER_WR_PACKER_STATS_EN
    output logic [15:0]                     frame_cnt,
    output logic [15:0]                     drop_cnt,
`endif
    output logic                            idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

    typedef struct packed {
        logic        restart;
        logic [3:0]  be;
        logic [31:0] data;
    } entry_t;

    state_e        state_q;
    logic          wrReq_q;
    logic [31:0]   addr_q, wrD_q, addrInc;
    logic [3:0]    be_q;
    logic [15:0]   halfData_q, halfData_d;
    logic          halfValid_q, halfValid_d, halfRestart_q, halfRestart_d;
    logic          overflow_q;
    logic [AW-1:0] wrPtr_q, rdPtr_q;
    logic [LW-1:0] level_q;
    entry_t        mem [FIFO_DEPTH];
    entry_t        pushEntry, headEntry;
    logic          pushEn, popEn, pushAccept, dropEn, fifoEmpty, fifoFull, sofSeen;

    // A sof pixel flushes any pending half first and then carries the restart marker on its own pair.
    always_comb begin
        pushEn        = 1'b0;
        pushEntry     = '0;
        halfData_d    = halfData_q;
        halfValid_d   = halfValid_q;
        halfRestart_d = halfRestart_q;
        if (pix_valid) begin
            if (pix_sof) begin
                if (halfValid_q) begin
                    pushEn    = 1'b1;
                    pushEntry = '{restart: halfRestart_q, be: 4'h3, data: {16'h0000, halfData_q}};
                end
                halfData_d    = pix_data;
                halfValid_d   = 1'b1;
                halfRestart_d = 1'b1;
            end else if (halfValid_q) begin
                pushEn        = 1'b1;
                pushEntry     = '{restart: halfRestart_q, be: 4'hf, data: {pix_data, halfData_q}};
                halfValid_d   = 1'b0;
                halfRestart_d = 1'b0;
            end else begin
                halfData_d    = pix_data;
                halfValid_d   = 1'b1;
                halfRestart_d = 1'b0;
            end
        end
    end

    assign sofSeen    = pix_valid && pix_sof;
    assign fifoEmpty  = (level_q == '0);
    assign fifoFull   = (level_q == LVL_FULL);
    assign popEn      = (state_q == IDLE) && !fifoEmpty && (!busy || burst_wr_rdy);
    assign pushAccept = pushEn && (!fifoFull || popEn);
    assign dropEn     = pushEn && !pushAccept;
    assign headEntry  = mem[rdPtr_q];
    assign addrInc    = ((addr_q + 32'd2) >= ADDR_LIMIT) ? BASE_ADDR : (addr_q + 32'd2);

    always_ff @(posedge clk) begin
        if (pushAccept) begin
            mem[wrPtr_q] <= pushEntry;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            halfData_q    <= '0;
            halfValid_q   <= 1'b0;
            halfRestart_q <= 1'b0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            halfData_q    <= halfData_d;
            halfValid_q   <= halfValid_d;
            halfRestart_q <= halfRestart_d;
            if (pushAccept) wrPtr_q <= wrPtr_q + PTR_ONE;
            if (popEn) rdPtr_q <= rdPtr_q + PTR_ONE;
            if (pushAccept && !popEn) level_q <= level_q + LVL_ONE;
            else if (!pushAccept && popEn) level_q <= level_q - LVL_ONE;
            // A drop in the same cycle as sof still leaves the flag set.
            if (dropEn) overflow_q <= 1'b1;
            else if (sofSeen) overflow_q <= 1'b0;
        end
    end

    // The pop happens on the IDLE->REQ edge so the head lands on the registered outputs during REQ.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            wrReq_q <= 1'b0;
            addr_q  <= BASE_ADDR;
            wrD_q   <= '0;
            be_q    <= 4'hf;
        end else begin
            case (state_q)
                IDLE: begin
                    if (popEn) begin
                        state_q <= REQ;
                        wrReq_q <= 1'b1;
                        wrD_q   <= headEntry.data;
                        be_q    <= headEntry.be;
                        if (headEntry.restart) addr_q <= BASE_ADDR;
                    end
                end
                REQ: begin
                    state_q <= GAP;
                    wrReq_q <= 1'b0;
                    addr_q  <= addrInc;
                end
                default: begin
                    state_q <= IDLE;
                    wrReq_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef HYPER_WR_PACKER_STATS_EN
    logic [15:0] frameCnt_q, dropCnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frameCnt_q <= '0;
            dropCnt_q  <= '0;
        end else begin
            if (sofSeen) frameCnt_q <= frameCnt_q + 16'd1;
            if (sofSeen) dropCnt_q <= dropEn ? 16'd1 : 16'd0;
            else if (dropEn && (dropCnt_q != 16'hFFFF)) dropCnt_q <= dropCnt_q + 16'd1;
        end
    end

    assign frame_cnt = frameCnt_q;
    assign drop_cnt  = dropCnt_q;
`else
    // Without statistics, drop events only feed the sticky overflow flag.
`endif

    assign wr_req     = wrReq_q;
    assign addr       = addr_q;
    assign wr_d       = wrD_q;
    assign wr_byte_en = be_q;
    assign mem_or_reg = 1'b0;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign idle       = fifoEmpty && !halfValid_q && (state_q == IDLE);

endmodule

// File: tb/tb_hyper_wr_packer.sv
// Directed bench for hyper_wr_packer: a pixel-packing model fills a scoreboard that is checked against observed writes.
// Stats outputs are checked too when HYPER_WR_PACKER_STATS_EN is defined.
module tb_hyper_wr_packer;

    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] LIMIT = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = '0;
    logic        pix_sof = 1'b0;
    logic        busy = 1'b0;
    logic        burst_wr_rdy = 1'b0;
    logic        wr_req, mem_or_reg, overflow, idle;
    logic [31:0] addr, wr_d;
    logic [3:0]  wr_byte_en;
    logic [3:0]  fifo_level;
`ifdef HYPER_WR_PACKER_STATS_EN
    logic [15:0] frame_cnt, drop_cnt;
`endif

    hyper_wr_packer #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .ADDR_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn), .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof),
        .wr_req(wr_req), .addr(addr), .wr_d(wr_d), .wr_byte_en(wr_byte_en), .mem_or_reg(mem_or_reg),
        .busy(busy), .burst_wr_rdy(burst_wr_rdy), .fifo_level(fifo_level), .overflow(overflow),
`ifdef HYPER_WR_PACKER_STATS_EN
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
`endif
        .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  be;
        logic        restart;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          cyc;
    } obs_t;

    exp_t sbQ[$];
    obs_t obsQ[$];
    int   cycle = 0;
    int   total = 0;
    int   bad = 0;

    logic        mHalfValid = 1'b0;
    logic [15:0] mHalf = '0;
    logic        mRestart = 1'b0;
    logic [31:0] mAddr = BASE;
    logic        mOverflow = 1'b0;
    int          mDrops = 0;
    int          mFrames = 0;
    int          lastReqCyc = -100;
    int          lastPixCyc = 0;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (resetn && wr_req) begin
            obs_t o;
            o.addr = addr;
            o.data = wr_d;
            o.be   = wr_byte_en;
            o.cyc  = cycle;
            obsQ.push_back(o);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic emit(input logic [31:0] d, input logic [3:0] be, input logic rst);
        exp_t e;
        if (sbQ.size() >= DEPTH) begin
            mDrops++;
            mOverflow = 1'b1;
        end else begin
            e.data = d;
            e.be = be;
            e.restart = rst;
            sbQ.push_back(e);
        end
    endtask

    // Drives one pixel for one cycle (caller sits just after a rising edge) and updates the packing model.
    task automatic applyStimulus(input logic [15:0] d, input logic sof, input int gap);
        pix_valid = 1'b1;
        pix_data = d;
        pix_sof = sof;
        lastPixCyc = cycle;
        if (sof) begin
            mFrames++;
            mDrops = 0;
            mOverflow = 1'b0;
            if (mHalfValid) emit({16'h0000, mHalf}, 4'h3, mRestart);
            mHalf = d;
            mHalfValid = 1'b1;
            mRestart = 1'b1;
        end else if (mHalfValid) begin
            emit({d, mHalf}, 4'hf, mRestart);
            mHalfValid = 1'b0;
            mRestart = 1'b0;
        end else begin
            mHalf = d;
            mHalfValid = 1'b1;
            mRestart = 1'b0;
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drainAndCheck(input int maxCycles);
        int n = 0;
        while (idle !== 1'b1 && n < maxCycles) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("drain_idle", {31'b0, idle}, 32'd1);
        checkOutput("drain_count", obsQ.size(), sbQ.size());
        while (obsQ.size() > 0 && sbQ.size() > 0) begin
            obs_t o;
            exp_t e;
            logic [31:0] ea;
            o = obsQ.pop_front();
            e = sbQ.pop_front();
            ea = e.restart ? BASE : mAddr;
            checkOutput("wr_addr", o.addr, ea);
            checkOutput("wr_d", o.data, e.data);
            checkOutput("wr_be", {28'b0, o.be}, {28'b0, e.be});
            checkOutput("req_spacing_ge3", {31'b0, (o.cyc - lastReqCyc) >= 3}, 32'd1);
            mAddr = ((ea + 32'd2) >= LIMIT) ? BASE : ea + 32'd2;
            lastReqCyc = o.cyc;
        end
        obsQ.delete();
        sbQ.delete();
    endtask

    initial begin
        int secondPixCyc;
        int firstCyc;
        int n;
        int s1;
        int s2;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wr_req", {31'b0, wr_req}, 32'd0);
        checkOutput("rst_addr", addr, BASE);
        checkOutput("rst_wr_d", wr_d, 32'd0);
        checkOutput("rst_be", {28'b0, wr_byte_en}, 32'hf);
        checkOutput("rst_mem_or_reg", {31'b0, mem_or_reg}, 32'd0);
        checkOutput("rst_level", {28'b0, fifo_level}, 32'd0);
        checkOutput("rst_overflow", {31'b0, overflow}, 32'd0);
        checkOutput("rst_idle", {31'b0, idle}, 32'd1);
        resetn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic packing and first-dword latency");
        applyStimulus(16'h0102, 1'b1, 1);
        applyStimulus(16'h0304, 1'b0, 1);
        secondPixCyc = lastPixCyc;
        applyStimulus(16'h0506, 1'b0, 1);
        applyStimulus(16'h0708, 1'b0, 1);
        firstCyc = (obsQ.size() > 0) ? obsQ[0].cyc : -1;
        checkOutput("first_latency", firstCyc, secondPixCyc + 2);
        drainAndCheck(50);

        $display("[TB] half-dword flush on sof and frame restart");
        applyStimulus(16'h1111, 1'b0, 1);
        applyStimulus(16'h2222, 1'b0, 1);
        applyStimulus(16'h3333, 1'b0, 1);
        applyStimulus(16'h4444, 1'b0, 1);
        applyStimulus(16'h5555, 1'b0, 1);
        applyStimulus(16'hAAAA, 1'b1, 1);
        applyStimulus(16'hBBBB, 1'b0, 1);
        drainAndCheck(50);

        $display("[TB] overflow while hyper_xface is busy");
        busy = 1'b1;
        for (int i = 0; i < 2 * (DEPTH + 2); i++) begin
            applyStimulus(16'h1000 + 16'(i), (i == 0), 0);
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("busy_no_req", obsQ.size(), 32'd0);
        checkOutput("full_level", {28'b0, fifo_level}, DEPTH);
        checkOutput("overflow_set", {31'b0, overflow}, {31'b0, mOverflow});
`ifdef HYPER_WR_PACKER_STATS_EN
        checkOutput("drop_cnt", {16'b0, drop_cnt}, mDrops);
        checkOutput("frame_cnt", {16'b0, frame_cnt}, mFrames);
`endif
        busy = 1'b0;
        drainAndCheck(200);
        checkOutput("overflow_sticky", {31'b0, overflow}, 32'd1);

        $display("[TB] address wrap at the limit");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(16'h2000 + 16'(i), (i == 0), 1);
            if (i == 0) checkOutput("overflow_clr_sof", {31'b0, overflow}, 32'd0);
        end
        drainAndCheck(100);

        $display("[TB] busy with burst_wr_rdy");
        busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(16'h3000 + 16'(i), (i == 0), 0);
        end
        repeat (2) @(posedge clk);
        #1;
        burst_wr_rdy = 1'b1;
        n = 0;
        while (obsQ.size() < 3 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        s1 = (obsQ.size() >= 3) ? obsQ[1].cyc - obsQ[0].cyc : -1;
        s2 = (obsQ.size() >= 3) ? obsQ[2].cyc - obsQ[1].cyc : -1;
        checkOutput("rdy_spacing1", s1, 32'd3);
        checkOutput("rdy_spacing2", s2, 32'd3);
        busy = 1'b0;
        burst_wr_rdy = 1'b0;
        drainAndCheck(50);

        $display("[TB] reset during a request");
        busy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(16'h4000 + 16'(i), (i == 0), 0);
        end
        repeat (2) @(posedge clk);
        #1;
        busy = 1'b0;
        n = 0;
        while (wr_req !== 1'b1 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("req_before_rst", {31'b0, wr_req}, 32'd1);
        checkOutput("level_in_req", {28'b0, fifo_level}, 32'd5);
        resetn = 1'b0;
        #1;
        checkOutput("arst_wr_req", {31'b0, wr_req}, 32'd0);
        checkOutput("arst_level", {28'b0, fifo_level}, 32'd0);
        checkOutput("arst_idle", {31'b0, idle}, 32'd1);
        checkOutput("arst_addr", addr, BASE);
`ifdef HYPER_WR_PACKER_STATS_EN
        checkOutput("arst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        checkOutput("arst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
`endif
        obsQ.delete();
        sbQ.delete();
        mHalfValid = 1'b0;
        mRestart = 1'b0;
        mAddr = BASE;
        mOverflow = 1'b0;
        mDrops = 0;
        mFrames = 0;
        lastReqCyc = -100;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        applyStimulus(16'h1234, 1'b1, 1);
        applyStimulus(16'h5678, 1'b0, 1);
        drainAndCheck(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
